// File: rtl/cic_decim_ctrl.sv
// cic_decim_ctrl: sequencing controller for a CIC decimator (flush, warm-up, decimation strobes, output handshake)
module cic_decim_ctrl #(
  parameter int RATE_WIDTH   = 8,
  parameter int DEFAULT_RATE = 6,
  parameter int STAGES       = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enabled,
  input  logic                  sample_valid,
  input  logic [RATE_WIDTH-1:0] cfg_rate,
  input  logic                  cfg_load,
  input  logic                  out_ready,
  output logic                  dp_clear,
  output logic                  integ_en,
  output logic                  comb_en,
  output logic                  out_valid,
  output logic                  overrun,
  output logic [RATE_WIDTH-1:0] active_rate,
  output logic [1:0]            state
);
  localparam logic [1:0] IDLE = 2'd0, FLUSH = 2'd1, SETTLE = 2'd2, RUN = 2'd3;
  localparam int WW = $clog2(STAGES + 2);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [RATE_WIDTH-1:0] RST_RATE = (DEFAULT_RATE < 2) ? RATE_WIDTH'(2) : RATE_WIDTH'(DEFAULT_RATE);

  function automatic logic [RATE_WIDTH-1:0] clamp(input logic [RATE_WIDTH-1:0] r);
    return (r < RATE_WIDTH'(2)) ? RATE_WIDTH'(2) : r;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [RATE_WIDTH-1:0] smp_cnt_q, smp_cnt_d;
  logic [WW-1:0]         warm_cnt_q, warm_cnt_d;
  logic [FW-1:0]         flush_cnt_q, flush_cnt_d;
  logic [RATE_WIDTH-1:0] pending_rate_q, pending_rate_d;
  logic [RATE_WIDTH-1:0] active_rate_q, active_rate_d;
  logic                  rate_change_q, rate_change_d;
  logic                  drain_q, drain_d;
  logic                  dp_clear_q, dp_clear_d;
  logic                  integ_en_q, integ_en_d;
  logic                  comb_en_q, comb_en_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  wrap;

  assign wrap = smp_cnt_q == active_rate_q - RATE_WIDTH'(1);

  always_comb begin
    state_d        = state_q;
    smp_cnt_d      = smp_cnt_q;
    warm_cnt_d     = warm_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    pending_rate_d = pending_rate_q;
    active_rate_d  = active_rate_q;
    rate_change_d  = rate_change_q;
    out_valid_d    = out_valid_q;
    overrun_d      = overrun_q;
    drain_d        = 1'b0;
    dp_clear_d     = 1'b0;
    integ_en_d     = 1'b0;
    comb_en_d      = 1'b0;
    if (cfg_load) begin
      pending_rate_d = clamp(cfg_rate);
      overrun_d      = 1'b0;
    end
    if (!enabled) begin
      state_d       = IDLE;
      smp_cnt_d     = '0;
      warm_cnt_d    = '0;
      flush_cnt_d   = '0;
      out_valid_d   = 1'b0;
      overrun_d     = 1'b0;
      rate_change_d = 1'b0;
      active_rate_d = cfg_load ? clamp(cfg_rate) : active_rate_q;
    end else if (state_q == IDLE) begin
      active_rate_d = cfg_load ? clamp(cfg_rate) : active_rate_q;
      state_d       = FLUSH;
      dp_clear_d    = 1'b1;
      flush_cnt_d   = '0;
    end else if (state_q == FLUSH) begin
      smp_cnt_d   = '0;
      warm_cnt_d  = '0;
      out_valid_d = 1'b0;
      if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) begin
        state_d       = SETTLE;
        active_rate_d = pending_rate_d;
        rate_change_d = 1'b0;
      end else begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        dp_clear_d  = 1'b1;
      end
    end else if (drain_q || (state_q == SETTLE && comb_en_q && rate_change_q)) begin
      // rate change: the frame just strobed has been presented (RUN) or discarded (SETTLE)
      state_d     = FLUSH;
      dp_clear_d  = 1'b1;
      flush_cnt_d = '0;
      smp_cnt_d   = '0;
      warm_cnt_d  = '0;
      out_valid_d = 1'b0;
    end else begin
      rate_change_d = rate_change_q | cfg_load;
      if (sample_valid) begin
        integ_en_d = 1'b1;
        comb_en_d  = wrap;
        smp_cnt_d  = wrap ? '0 : smp_cnt_q + 1'b1;
      end
      if (state_q == RUN) begin
        out_valid_d = comb_en_q | (out_valid_q & ~out_ready);
        overrun_d   = overrun_d | (comb_en_q & out_valid_q & ~out_ready);
        drain_d     = comb_en_q & rate_change_q;
      end else if (comb_en_q) begin
        // the strobe after STAGES discarded ones is the first real output
        state_d     = (warm_cnt_q == WW'(STAGES)) ? RUN : SETTLE;
        out_valid_d = warm_cnt_q == WW'(STAGES);
        warm_cnt_d  = (warm_cnt_q == WW'(STAGES)) ? warm_cnt_q : warm_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      smp_cnt_q      <= '0;
      warm_cnt_q     <= '0;
      flush_cnt_q    <= '0;
      pending_rate_q <= RST_RATE;
      active_rate_q  <= RST_RATE;
      rate_change_q  <= 1'b0;
      drain_q        <= 1'b0;
      dp_clear_q     <= 1'b0;
      integ_en_q     <= 1'b0;
      comb_en_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      smp_cnt_q      <= smp_cnt_d;
      warm_cnt_q     <= warm_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
      pending_rate_q <= pending_rate_d;
      active_rate_q  <= active_rate_d;
      rate_change_q  <= rate_change_d;
      drain_q        <= drain_d;
      dp_clear_q     <= dp_clear_d;
      integ_en_q     <= integ_en_d;
      comb_en_q      <= comb_en_d;
      out_valid_q    <= out_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign dp_clear    = dp_clear_q;
  assign integ_en    = integ_en_q;
  assign comb_en     = comb_en_q;
  assign out_valid   = out_valid_q;
  assign overrun     = overrun_q;
  assign active_rate = active_rate_q;
  assign state       = state_q;
endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb_cic_decim_ctrl: directed bench; comb strobes and output accepts go through a scoreboard, state checks are inline
module tb_cic_decim_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, enabled, sample_valid, cfg_load, out_ready;
  logic [7:0] cfg_rate;
  logic       dp_clear, integ_en, comb_en, out_valid, overrun;
  logic [7:0] active_rate;
  logic [1:0] state;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         k, j, m, n0;

  typedef struct { int cyc; int rate; } comb_t;
  comb_t cq[$];
  int    aq[$];
  comb_t mon_e;
  int    mon_a;

  cic_decim_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enabled(enabled), .sample_valid(sample_valid),
    .cfg_rate(cfg_rate), .cfg_load(cfg_load), .out_ready(out_ready),
    .dp_clear(dp_clear), .integ_en(integ_en), .comb_en(comb_en), .out_valid(out_valid),
    .overrun(overrun), .active_rate(active_rate), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", n, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic neg(input int c);
    wait_cyc(c);
    @(negedge clk);
  endtask

  task automatic push_comb(input int c, input int r);
    comb_t e;
    e.cyc = c;
    e.rate = r;
    cq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && comb_en) begin
      if (cq.size() == 0) chk("comb_unexpected", cyc, -1);
      else begin
        mon_e = cq.pop_front();
        chk("comb_cycle", cyc, mon_e.cyc);
        chk("comb_rate", int'(active_rate), mon_e.rate);
      end
    end
    if (rst_n && out_valid && out_ready) begin
      if (aq.size() == 0) chk("accept_unexpected", cyc, -1);
      else begin
        mon_a = aq.pop_front();
        chk("accept_cycle", cyc, mon_a);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 0; enabled = 0; sample_valid = 0; cfg_rate = 0; cfg_load = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dp_clear", dp_clear, 0);
    chk("rst_integ_en", integ_en, 0);
    chk("rst_comb_en", comb_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_active_rate", active_rate, 6);
    chk("rst_state", state, 0);
    @(posedge clk);
    #1 rst_n = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_hold_state", state, 0);
    chk("idle_hold_dp_clear", dp_clear, 0);
    // startup at R=6, continuous samples
    k = cyc + 2;
    wait_cyc(k);
    enabled = 1; sample_valid = 1;
    push_comb(k+9, 6); push_comb(k+15, 6); push_comb(k+21, 6); push_comb(k+27, 6);
    push_comb(k+33, 6); push_comb(k+39, 6); push_comb(k+45, 6);
    push_comb(k+59, 10); push_comb(k+69, 10); push_comb(k+79, 10);
    aq.push_back(k+22); aq.push_back(k+35); aq.push_back(k+40); aq.push_back(k+46); aq.push_back(k+80);
    neg(k+1);  chk("su_dp_clear_c1", dp_clear, 1); chk("su_state_flush", state, 1);
    neg(k+2);  chk("su_dp_clear_c2", dp_clear, 1);
    neg(k+3);  chk("su_dp_clear_c3", dp_clear, 0); chk("su_state_settle", state, 2); chk("su_integ_c3", integ_en, 0);
    neg(k+4);  chk("su_integ_c4", integ_en, 1);
    neg(k+21); chk("su_state_c21", state, 2); chk("su_out_valid_c21", out_valid, 0);
    neg(k+22); chk("su_state_c22", state, 3); chk("su_out_valid_c22", out_valid, 1);
    // backpressure across two strobes
    wait_cyc(k+23); out_ready = 0;
    neg(k+28); chk("bp_out_valid_first", out_valid, 1); chk("bp_no_overrun_yet", overrun, 0);
    neg(k+34); chk("bp_out_valid_held", out_valid, 1); chk("bp_overrun", overrun, 1);
    wait_cyc(k+35); out_ready = 1;
    neg(k+36); chk("bp_out_valid_drop", out_valid, 0); chk("bp_overrun_sticky", overrun, 1);
    // rate change to 10 mid-frame
    wait_cyc(k+42); cfg_rate = 10; cfg_load = 1;
    wait_cyc(k+43); cfg_load = 0;
    neg(k+43); chk("rc_overrun_cleared", overrun, 0); chk("rc_rate_not_yet", active_rate, 6);
    neg(k+46); chk("rc_last_out_state", state, 3); chk("rc_last_out_valid", out_valid, 1);
    neg(k+47); chk("rc_flush_state", state, 1); chk("rc_flush_clear", dp_clear, 1); chk("rc_flush_out_valid", out_valid, 0);
    neg(k+49); chk("rc_settle_state", state, 2); chk("rc_active_rate", active_rate, 10);
    neg(k+80); chk("rc_run_state", state, 3); chk("rc_run_out_valid", out_valid, 1);
    wait_cyc(k+82); enabled = 0; sample_valid = 0;
    neg(k+83);
    chk("dis_state", state, 0); chk("dis_integ", integ_en, 0); chk("dis_comb", comb_en, 0);
    chk("dis_out_valid", out_valid, 0); chk("dis_dp_clear", dp_clear, 0);
    // clamp in IDLE: 0 then 1
    wait_cyc(k+84); cfg_rate = 0; cfg_load = 1;
    wait_cyc(k+85); cfg_rate = 1;
    neg(k+85); chk("clamp_rate0", active_rate, 2);
    wait_cyc(k+86); cfg_load = 0;
    neg(k+86); chk("clamp_rate1", active_rate, 2);
    j = k + 88;
    wait_cyc(j); enabled = 1; sample_valid = 1;
    push_comb(j+5, 2); push_comb(j+7, 2); push_comb(j+9, 2); push_comb(j+11, 2);
    aq.push_back(j+10); aq.push_back(j+12);
    wait_cyc(j+12); enabled = 0; sample_valid = 0;
    // abort during SETTLE with simultaneous load of 8
    m = j + 15;
    wait_cyc(m); enabled = 1; sample_valid = 1;
    push_comb(m+5, 2);
    wait_cyc(m+6); enabled = 0; cfg_load = 1; cfg_rate = 8;
    wait_cyc(m+7); cfg_load = 0;
    neg(m+7);
    chk("abort_state", state, 0); chk("abort_integ", integ_en, 0); chk("abort_comb", comb_en, 0);
    chk("abort_dp_clear", dp_clear, 0); chk("abort_active_rate", active_rate, 8);
    n0 = m + 8;
    wait_cyc(n0); enabled = 1;
    push_comb(n0+11, 8); push_comb(n0+19, 8); push_comb(n0+27, 8);
    aq.push_back(n0+28);
    neg(n0+1);  chk("re_dp_clear", dp_clear, 1); chk("re_state_flush", state, 1);
    neg(n0+3);  chk("re_state_settle", state, 2); chk("re_active_rate", active_rate, 8);
    neg(n0+27); chk("re_state_c27", state, 2);
    neg(n0+28); chk("re_state_run", state, 3); chk("re_out_valid", out_valid, 1);
    wait_cyc(n0+29); enabled = 0; sample_valid = 0;
    neg(n0+32);
    chk("end_state", state, 0);
    chk("end_comb_pending", cq.size(), 0);
    chk("end_accept_pending", aq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cic_decim_ctrl.md
# cic_decim_ctrl

Sequencing controller for the two-stage CIC decimator datapath in the MSO acquisition chain. Owns the decimation counter, the integrator/comb enables and the datapath clear. Applies decimation-rate changes safely at frame boundaries, discards comb warm-up outputs, and presents decimated samples downstream over a valid/ready handshake with overrun detection.

## Interface
- RATE_WIDTH, 8: width of the decimation factor R.
- DEFAULT_RATE, 6: R value after reset.
- STAGES, 2: comb stages; this many decimated outputs are discarded after every flush.
- FLUSH_CYCLES, 2: cycles `dp_clear` is held per flush, at least 1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- enabled  in  1  level; run request.
- sample_valid  in  1  a new ADC sample is on `data_in` this cycle.
- cfg_rate  in  RATE_WIDTH  requested R; values below 2 are clamped to 2.
- cfg_load  in  1  one-cycle pulse; captures `cfg_rate` into `pending_rate`.
- out_ready  in  1  downstream accepts the decimated sample.
- dp_clear  out  1  synchronous clear of all integrator and comb registers.
- integ_en  out  1  integrator accumulate enable.
- comb_en  out  1  decimation strobe for the comb stages.
- out_valid  out  1  decimated sample is valid.
- overrun  out  1  sticky; a decimated sample was lost.
- active_rate  out  RATE_WIDTH  R currently in use.
- state  out  2  IDLE=0, FLUSH=1, SETTLE=2, RUN=3.

## Operation
- All outputs are registered. Reset value of every output is 0, except `active_rate`, which resets to DEFAULT_RATE (clamped). Internal `pending_rate` resets to DEFAULT_RATE; `rate_change` resets to 0.
- Internal counters:
  - `smp_cnt`, 0..R-1: counts accepted samples.
  - `warm_cnt`, 0..STAGES: counts comb strobes since the last flush.
  - `flush_cnt`: counts flush cycles.
- IDLE: `integ_en`, `comb_en`, `out_valid` and `dp_clear` are all 0.
  - `cfg_load` updates both `pending_rate` and `active_rate`.
  - `enabled`=1 moves the block to FLUSH.
- FLUSH: `dp_clear`=1 for FLUSH_CYCLES cycles. `smp_cnt`, `warm_cnt` and `out_valid` are cleared. `sample_valid` is ignored.
  - On the last flush cycle, `active_rate` is loaded from `pending_rate` and `rate_change` is cleared. The block then moves to SETTLE.
- SETTLE and RUN, for each `sample_valid`=1:
  - Next cycle `integ_en`=1 and `smp_cnt` increments.
  - If `smp_cnt` was R-1, it wraps to 0 and `comb_en`=1 in the same cycle as that `integ_en`.
- SETTLE: each `comb_en` increments `warm_cnt`. No `out_valid` is produced. When `warm_cnt` reaches STAGES, the block moves to RUN.
- RUN: each `comb_en` sets `out_valid` on the following cycle. `out_valid` stays high until a cycle with `out_valid`=1 and `out_ready`=1, then drops next cycle.
  - If a new result arrives while `out_valid`=1 and `out_ready`=0: set `overrun`. `out_valid` stays 1; the datapath holds the newest sample.
  - If the result arrives in the same cycle as an accept: no overrun, and `out_valid` stays 1.
- Rate change in SETTLE or RUN:
  - `cfg_load` sets `pending_rate` and a `rate_change` flag.
  - At the next `comb_en`, that frame's output is still delivered in RUN. The block then moves to FLUSH.
- `cfg_load` during FLUSH only updates `pending_rate`; it takes effect on FLUSH exit.
- `overrun` is cleared by `cfg_load` or by returning to IDLE.
- `enabled`=0 in any state: IDLE next cycle. All enables and `out_valid` clear; `smp_cnt` and `warm_cnt` clear.
  - A simultaneous `cfg_load` is still captured, as an IDLE load.
- Reset asserted mid-operation: immediate return to reset values. Any pending rate change is lost.

## Timing
- Sample `enabled` rising at edge 0:
  - `dp_clear` is high in cycles 1..FLUSH_CYCLES.
  - SETTLE starts at cycle FLUSH_CYCLES+1.
  - `sample_valid` is accepted from that cycle on.
- `sample_valid` at cycle n gives `integ_en` at n+1. `comb_en` coincides with the R-th `integ_en` of a frame. `out_valid` rises one cycle after `comb_en`.
- With continuous samples, `comb_en` period is exactly R cycles.
- First `out_valid` comes STAGES+1 frames after FLUSH exit.
- The `enabled` fall to IDLE takes 1 cycle.

## Test plan
- Reset: hold `rst_n`=0 → all outputs 0, `active_rate`=6, `state`=0. Release with `enabled`=0 → stays IDLE.
- Startup, R=6, FLUSH_CYCLES=2, `sample_valid` continuous from cycle 0, `enabled` rising at edge 0:
  - `dp_clear` in cycles 1-2.
  - `integ_en` from cycle 4.
  - `comb_en` at cycles 9, 15, 21.
  - `out_valid` first at cycle 22; `state`=3 from cycle 22.
- Backpressure in RUN, R=6: hold `out_ready`=0 across two `comb_en` → `overrun`=1 and `out_valid` stays 1. Then set `out_ready`=1 → `out_valid` drops next cycle; `overrun` stays 1 until `cfg_load`.
- Rate change in RUN: `cfg_load` with `cfg_rate`=10 mid-frame:
  - The current frame completes with R=6 and its output is delivered.
  - Then FLUSH; `active_rate`=10.
  - `comb_en` spacing is 10 after SETTLE.
- Clamp: `cfg_load` with `cfg_rate`=0 and then 1 in IDLE → `active_rate`=2. `comb_en` then fires every 2nd sample.
- Abort: `enabled` dropped during SETTLE with `cfg_load`=1 and `cfg_rate`=8 in the same cycle → IDLE next cycle, all enables 0, `active_rate`=8. Re-enable → full FLUSH and SETTLE sequence repeats.
